// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Load/store unit between the execute stage and the data RAM.
//               Accepts one load or store per request handshake and checks
//               its alignment. Stores are issued one byte lane per cycle
//               (byte in bits [7:0], one-hot lane mask). Loads read the whole
//               word once, then extract and sign-/zero-extend the field.
//               Every request ends with a single-cycle response pulse.
//
// Ports       : clk, reset        - clock, synchronous active-high reset
//               req_*_i / _o      - request handshake and captured fields
//               rsp_*_o           - one-cycle response (data / error)
//               mem_*_o / _i      - data-RAM port (en, addr, wdata, mask,
//                                   rdata)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32   // only 32 is supported
) (
    input  logic                  clk,
    input  logic                  reset,
    // request
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    // response
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    // data RAM port
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_wr_mask_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_we;
    logic                  r_unsigned;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic [1:0]            r_beat;
    logic [DATA_WIDTH-1:0] r_rdata_word;

    logic                  w_accept;
    logic                  w_req_err;
    logic [1:0]            w_last_beat;
    logic [1:0]            w_lane;
    logic [1:0]            w_off;
    logic [7:0]            w_wr_byte;
    logic [7:0]            w_ld_byte;
    logic [15:0]           w_ld_half;
    logic [DATA_WIDTH-1:0] w_ld_ext;
    logic                  w_mem_en;

    assign req_ready_o = (r_state == ST_IDLE) && !reset;
    assign w_accept    = req_valid_i && req_ready_o;

    assign w_req_err = (req_size_i == 2'b11)
                     || ((req_size_i == c_size_half) && req_addr_i[0])
                     || ((req_size_i == c_size_word) && (req_addr_i[1:0] != 2'b00));

    // Index of the final write beat: k-1 for k = 1/2/4 beats.
    always_comb begin
        w_last_beat = 2'd3;
        case (r_size)
            c_size_byte: w_last_beat = 2'd0;
            c_size_half: w_last_beat = 2'd1;
            default:     w_last_beat = 2'd3;
        endcase
    end

    // Aligned accesses never carry past lane 3, so 2-bit wrap is harmless.
    assign w_lane    = r_addr[1:0] + r_beat;
    assign w_wr_byte = r_wdata[{r_beat, 3'b000} +: 8];

    // Load extraction; halves are 2-byte aligned, so offset bit 1 picks them.
    assign w_off     = r_addr[1:0];
    assign w_ld_byte = r_rdata_word[{w_off, 3'b000} +: 8];
    assign w_ld_half = r_rdata_word[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_ext = r_rdata_word;
        case (r_size)
            c_size_byte: w_ld_ext = {{24{~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
            c_size_half: w_ld_ext = {{16{~r_unsigned & w_ld_half[15]}}, w_ld_half};
            default:     w_ld_ext = r_rdata_word;
        endcase
    end

    // State register and request capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_size       <= 2'b00;
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_beat       <= 2'd0;
            r_rdata_word <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr     <= req_addr_i;
                r_size     <= req_size_i;
                r_we       <= req_we_i;
                r_unsigned <= req_unsigned_i;
                r_wdata    <= req_wdata_i;
                r_err      <= w_req_err;
                r_beat     <= 2'd0;
            end else if (r_state == ST_WR) begin
                r_beat <= r_beat + 2'd1;
            end
            // Synchronous RAM: read word is valid during RD_WAIT.
            if (r_state == ST_RD_WAIT) begin
                r_rdata_word <= mem_rdata_i;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)     w_state_nxt = ST_RESP;
                    else if (req_we_i) w_state_nxt = ST_WR;
                    else               w_state_nxt = ST_RD;
                end
            end
            ST_WR: begin
                if (r_beat == w_last_beat) w_state_nxt = ST_RESP;
            end
            ST_RD:      w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: w_state_nxt = ST_RESP;
            ST_RESP:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory enable drops combinationally with reset, so a beat that is in
    // flight when reset arrives is never committed to the RAM.
    assign w_mem_en = ((r_state == ST_WR) || (r_state == ST_RD)) && !reset;

    // Outputs; all memory fields are zero whenever the RAM is not selected.
    always_comb begin
        mem_en_o      = w_mem_en;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_wr_mask_o = 4'b0000;
        rsp_valid_o   = 1'b0;
        rsp_err_o     = 1'b0;
        rsp_rdata_o   = '0;
        if (w_mem_en) begin
            mem_addr_o = {r_addr[ADDR_WIDTH-1:2], 2'b00};
            if (r_state == ST_WR) begin
                mem_wr_mask_o = 4'b0001 << w_lane;
                mem_wdata_o   = {{(DATA_WIDTH-8){1'b0}}, w_wr_byte};
            end
        end
        if (r_state == ST_RESP) begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = r_err;
            if (!r_err && !r_we) rsp_rdata_o = w_ld_ext;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit that initiates accesses on the core's data-RAM port (`en` / `address` / `data_in` / `data_out` / `wr_mask`). It sits between the execute stage and the data RAM. It accepts one load or store per request handshake, checks alignment, and returns a single-cycle response. Each write beat carries its byte in bits [7:0] with a one-hot lane mask, so stores are serialized one byte lane per cycle. Loads read the whole word once, then extract and sign-/zero-extend the addressed field.

## Interface
- `ADDR_WIDTH`, 32, byte address width (`API_ADDR_WIDTH`)
- `DATA_WIDTH`, 32, data width (`API_DATA_WIDTH`); only 32 is supported
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `req_valid_i`  in  1  core presents a request
- `req_ready_o`  out  1  LSU can accept; request accepted on the edge where `req_valid_i && req_ready_o`
- `req_we_i`  in  1  1 = store, 0 = load
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned_i`  in  1  loads: 1 = zero-extend, 0 = sign-extend
- `req_addr_i`  in  ADDR_WIDTH  byte address
- `req_wdata_i`  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- `rsp_valid_o`  out  1  one-cycle response pulse
- `rsp_rdata_o`  out  DATA_WIDTH  extended load data; 0 for stores and errors
- `rsp_err_o`  out  1  misaligned or illegal size; qualified by `rsp_valid_o`
- `mem_en_o`  out  1  RAM chip select
- `mem_addr_o`  out  ADDR_WIDTH  `{req_addr[31:2], 2'b00}`
- `mem_wdata_o`  out  DATA_WIDTH  `{24'b0, byte}` during write beats
- `mem_wr_mask_o`  out  4  one-hot lane on write beats; 0000 on reads
- `mem_rdata_i`  in  DATA_WIDTH  RAM read word

## Operation
- **Request capture:** `addr`, `size`, `we`, `unsigned` and `wdata` are latched at acceptance. Request inputs are ignored after that edge.
- **States:** IDLE, WR, RD, RD_WAIT, RESP. `req_ready_o = (state==IDLE) && !reset`.
- **Alignment check (at acceptance):**
  - Error when size = 11, or size = 01 with `addr[0]` = 1, or size = 10 with `addr[1:0]` ≠ 00.
  - On error the FSM goes IDLE→RESP with `rsp_err_o=1` and `rsp_rdata_o=0`. `mem_en_o` is never asserted.
- **Store:**
  - IDLE→WR. The beat count k is 1/2/4 for byte/half/word.
  - Beat j (j = 0..k-1) drives `mem_en_o=1`, `mem_wr_mask_o = 1<<(addr[1:0]+j)` and `mem_wdata_o[7:0] = wdata[8j+7:8j]`.
  - Lanes are written in ascending order. `mem_addr_o` is constant for all beats. After the last beat the FSM goes to RESP.
- **Load:**
  - IDLE→RD. RD drives `mem_en_o=1` and `mem_wr_mask_o=0000` for one cycle.
  - RD_WAIT drives `mem_en_o=0`; `mem_rdata_i` is registered at the end of RD_WAIT. The FSM then goes to RESP.
  - Extraction by offset o = `addr[1:0]`:
    - byte = `word[8o+7:8o]`
    - half = `word[8o+15:8o]`
    - word = `word`
  - Extension to 32 bits: sign-extend when `unsigned`=0, zero-extend otherwise.
- **RESP:** `rsp_valid_o=1` for exactly one cycle, then IDLE.
- **Idle memory outputs:** whenever `mem_en_o=0`, `mem_addr_o`, `mem_wdata_o` and `mem_wr_mask_o` are 0.

## Timing
- **Reset values:**
  - FSM is in IDLE.
  - `rsp_valid_o`, `rsp_err_o`, `rsp_rdata_o`, `mem_en_o`, `mem_addr_o`, `mem_wdata_o` and `mem_wr_mask_o` are all 0.
  - `req_ready_o` is 0 while `reset`=1 and 1 in the first cycle after deassertion.
- **Latency,** with the request accepted at edge N:
  - Store: `mem_en_o` high in cycles N+1..N+k; `rsp_valid_o` in cycle N+k+1.
  - Load: `mem_en_o` high in cycle N+1; `rsp_valid_o` in cycle N+3.
  - Error: `rsp_valid_o` in cycle N+1.
- **Throughput:** next acceptance is possible at earliest at the edge ending the first IDLE cycle after RESP. There are no back-to-back requests.
- **Response outputs:** `rsp_rdata_o` and `rsp_err_o` hold their value only while `rsp_valid_o`=1. Otherwise they are 0.
- **Reset mid-operation:**
  - Synchronous reset aborts the operation at the next edge: the FSM returns to IDLE and all outputs go to reset values.
  - Remaining write beats are not issued and no response is produced.
  - Bytes already written stay written.
- **Simultaneous events:** `req_valid_i` asserted while the LSU is busy is simply not accepted and has no effect.

## Test plan
- **Word store:** store word 0xDEADBEEF at 0x10 → `mem_en_o` high for 4 cycles with `mem_addr_o`=0x10.
  - Masks in order: 0001, 0010, 0100, 1000.
  - `mem_wdata_o` in order: 0xEF, 0xBE, 0xAD, 0xDE.
  - `rsp_valid_o` in cycle N+5 with `rsp_err_o`=0 and `rsp_rdata_o`=0.
- **Word load** (RAM model preloaded by scenario 1): load word at 0x10 → `mem_en_o` in N+1 with mask 0000; `rsp_valid_o` in N+3 with `rsp_rdata_o`=0xDEADBEEF.
- **Byte and half loads** at that word:
  - Signed byte at 0x13 → 0xFFFFFFDE.
  - Unsigned byte at 0x13 → 0x000000DE.
  - Signed half at 0x12 → 0xFFFFDEAD.
  - Unsigned half at 0x10 → 0x0000BEEF.
- **Half store:** store half 0x1234 at 0x16 → 2 beats, masks 0100 then 1000, data 0x34 then 0x12. A subsequent word load at 0x14 returns 0x1234xxxx, where xxxx is the prior contents.
- **Errors:** word load at 0x11, half store at 0x13, and size=11 → `rsp_err_o`=1 in N+1, `mem_en_o` never high, `req_ready_o` high again in N+2.
- **Reset mid-store:** assert `reset` during the second beat of a word store → `mem_en_o`=0 from the next cycle, no `rsp_valid_o`. RAM lane 0 holds the new byte and lanes 1-3 are unchanged. `req_ready_o`=1 in the first cycle after reset drops.
